// File: rtl/shape_list_sequencer.sv
// shape_list_sequencer: walks the shape-record list once per frame and
// hands each enabled record to the renderer, one draw at a time.
//
// Ports
//   clk, rst_n    clock, async active-low reset
//   frame_start   one-cycle request to render the list
//   count         records to render, sampled when frame_start is taken
//   mem_re        record-memory read enable (sync read, data next cycle)
//   mem_addr      record index
//   rec_data      {ty,x0,y0,size}, MSB first
//   ty,x0,y0,size latched record fields, stable for the whole draw
//   start         one-cycle renderer start pulse
//   rend_done     renderer done pulse
//   busy          traversal in progress
//   frame_done    one-cycle pulse when the list is finished
module shape_list_sequencer #(
  parameter int CORDW = 10,
  parameter int DATAW = 12,
  parameter int ADDRW = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic [ADDRW:0]               count,
  output logic                         mem_re,
  output logic [ADDRW-1:0]             mem_addr,
  input  logic [2*DATAW+2*CORDW-1:0]   rec_data,
  output logic [DATAW-1:0]             ty,
  output logic [CORDW-1:0]             x0,
  output logic [CORDW-1:0]             y0,
  output logic [DATAW-1:0]             size,
  output logic                         start,
  input  logic                         rend_done,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int RW = 2*DATAW + 2*CORDW;
  localparam logic [ADDRW:0] ONE  = {{ADDRW{1'b0}}, 1'b1};
  localparam logic [ADDRW:0] MAXN = {1'b1, {ADDRW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state;
  logic [ADDRW:0] n;
  logic [ADDRW:0] idx;
  logic [ADDRW:0] idx_nx;

  logic [DATAW-1:0] rd_ty;
  logic [CORDW-1:0] rd_x0;
  logic [CORDW-1:0] rd_y0;
  logic [DATAW-1:0] rd_size;

  assign rd_ty   = rec_data[RW-1 -: DATAW];
  assign rd_x0   = rec_data[2*CORDW+DATAW-1 -: CORDW];
  assign rd_y0   = rec_data[CORDW+DATAW-1 -: CORDW];
  assign rd_size = rec_data[DATAW-1:0];

  // idx is one bit wider than mem_addr so a full list never wraps
  assign idx_nx = idx + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n          <= '0;
      idx        <= '0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      ty         <= '0;
      x0         <= '0;
      y0         <= '0;
      size       <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            busy <= 1'b1;
            idx  <= '0;
            n    <= (count > MAXN) ? MAXN : count;
            if (count == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_FETCH;
              mem_re   <= 1'b1;
              mem_addr <= '0;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          ty   <= rd_ty;
          x0   <= rd_x0;
          y0   <= rd_y0;
          size <= rd_size;
          // all-ones type marks a disabled entry
          if (rd_ty == '1) begin
            state <= S_NEXT;
          end else begin
            state <= S_ISSUE;
            start <= 1'b1;
          end
        end
        S_ISSUE: state <= S_DRAW;
        S_DRAW: begin
          if (rend_done) state <= S_NEXT;
        end
        S_NEXT: begin
          if (idx == n - ONE) begin
            state <= S_DONE;
          end else begin
            idx      <= idx_nx;
            mem_re   <= 1'b1;
            mem_addr <= idx_nx[ADDRW-1:0];
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_list_sequencer.sv
// tb_shape_list_sequencer: random and directed frames on two sizes of
// the sequencer, checked against a list-level model of the traversal.
module tb_shape_list_sequencer;

  localparam int RW = 44;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] fs, re, start, rdone, busy, fd;
  logic [1:0][5:0] cnt;
  logic [4:0] addr0;
  logic [1:0] addr1;
  logic [1:0][RW-1:0] rdata;
  logic [1:0][11:0] ty, sz;
  logic [1:0][9:0] x0, y0;

  logic [RW-1:0] mem [2][32];
  int cyc = 0;
  bit noise;
  int dly_fix;
  int errs = 0;
  int checks = 0;

  shape_list_sequencer #(.CORDW(10), .DATAW(12), .ADDRW(5)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_start(fs[0]),
    .count(cnt[0]), .mem_re(re[0]), .mem_addr(addr0),
    .rec_data(rdata[0]), .ty(ty[0]), .x0(x0[0]), .y0(y0[0]),
    .size(sz[0]), .start(start[0]), .rend_done(rdone[0]),
    .busy(busy[0]), .frame_done(fd[0])
  );

  shape_list_sequencer #(.CORDW(10), .DATAW(12), .ADDRW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs[1]),
    .count(cnt[1][2:0]), .mem_re(re[1]), .mem_addr(addr1),
    .rec_data(rdata[1]), .ty(ty[1]), .x0(x0[1]), .y0(y0[1]),
    .size(sz[1]), .start(start[1]), .rend_done(rdone[1]),
    .busy(busy[1]), .frame_done(fd[1])
  );

  function automatic int addr_of(int g);
    return (g == 0) ? int'(addr0) : int'(addr1);
  endfunction

  function automatic logic [RW-1:0] flds(int g);
    return {ty[g], x0[g], y0[g], sz[g]};
  endfunction

  function automatic logic [63:0] outs(int g);
    return 64'({re[g], start[g], busy[g], fd[g],
                5'(addr_of(g)), flds(g)});
  endfunction

  function automatic logic [RW-1:0] rec(int t, int x, int y, int s);
    return {12'(t), 10'(x), 10'(y), 12'(s)};
  endfunction

  function automatic bit dis(logic [RW-1:0] r);
    return r[RW-1 -: 12] == 12'hFFF;
  endfunction

  function automatic int maxn(int g);
    return (g == 0) ? 32 : 4;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // record memory, synchronous read
  always @(posedge clk) begin
    if (re[0]) rdata[0] <= mem[0][addr0];
    if (re[1]) rdata[1] <= mem[1][addr1];
  end

  // renderer: done pulse some cycles after start, optional stray pulses
  int rcnt [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt[0] <= 0;
      rcnt[1] <= 0;
      rdone   <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        rdone[g] <= 1'b0;
        if (start[g])
          rcnt[g] <= (dly_fix > 0) ? dly_fix : int'($urandom_range(1, 8));
        else if (rcnt[g] == 1) begin
          rcnt[g]  <= 0;
          rdone[g] <= 1'b1;
        end else if (rcnt[g] > 1)
          rcnt[g] <= rcnt[g] - 1;
        else if (noise && $urandom_range(0, 15) == 0)
          rdone[g] <= 1'b1;
      end
    end
  end

  // monitor
  logic [RW-1:0] hold [2];
  bit drawing [2], pend [2], hp [2], pdis [2];
  int dcyc [2], prevre [2], firstre [2], firstst [2], fdcyc [2];
  int fdc [2] = '{0, 0};
  int busyc [2] = '{0, 0};
  int unstab [2] = '{0, 0};
  int gapbad [2] = '{0, 0};
  int disbad [2] = '{0, 0};
  logic [RW-1:0] sq [2][$];
  int aq [2][$];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        drawing[g] <= 1'b0;
        pend[g]    <= 1'b0;
        hp[g]      <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (rdone[g] && drawing[g]) begin
          drawing[g] <= 1'b0;
          pend[g]    <= 1'b1;
          dcyc[g]    <= cyc;
        end
        if (re[g]) begin
          if (pend[g] && cyc != dcyc[g] + 2)
            gapbad[g] <= gapbad[g] + 1;
          if (hp[g] && pdis[g] && cyc != prevre[g] + 3)
            disbad[g] <= disbad[g] + 1;
          if (aq[g].size() == 0) firstre[g] <= cyc;
          aq[g].push_back(addr_of(g));
          pend[g]   <= 1'b0;
          hp[g]     <= 1'b1;
          prevre[g] <= cyc;
          pdis[g]   <= dis(mem[g][addr_of(g)]);
        end
        if (start[g]) begin
          if (sq[g].size() == 0) firstst[g] <= cyc;
          sq[g].push_back(flds(g));
          drawing[g] <= 1'b1;
          hold[g]    <= flds(g);
        end else if (drawing[g] && flds(g) != hold[g])
          unstab[g] <= unstab[g] + 1;
        if (fd[g]) begin
          fdc[g]   <= fdc[g] + 1;
          fdcyc[g] <= cyc;
          pend[g]  <= 1'b0;
          hp[g]    <= 1'b0;
        end
        if (busy[g]) busyc[g] <= busyc[g] + 1;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int t0 [2], s_fd [2], s_busy [2], s_un [2], s_gap [2], s_dis [2];

  task automatic launch(int g, int c);
    sq[g].delete();
    aq[g].delete();
    s_fd[g]   = fdc[g];
    s_busy[g] = busyc[g];
    s_un[g]   = unstab[g];
    s_gap[g]  = gapbad[g];
    s_dis[g]  = disbad[g];
    cnt[g] = c[5:0];
    @(posedge clk); #1;
    fs[g] = 1'b1;
    t0[g] = cyc;
    @(posedge clk); #1;
    fs[g] = 1'b0;
  endtask

  task automatic wait_done(int g, bit poke);
    int k = 0;
    while (fdc[g] == s_fd[g] && k < 5000) begin
      @(posedge clk); #1;
      k++;
      if (poke && busy[g] && $urandom_range(0, 15) == 0) begin
        fs[g]  = 1'b1;
        cnt[g] = 6'($urandom_range(0, 63));
      end else
        fs[g] = 1'b0;
    end
    fs[g] = 1'b0;
    chk("frame_timeout", 64'(k >= 5000), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(int g, int c);
    int n;
    logic [RW-1:0] ex [$];
    n = (c > maxn(g)) ? maxn(g) : c;
    chk("n_fetch", 64'(aq[g].size()), 64'(n));
    for (int i = 0; i < n && i < aq[g].size(); i++)
      chk("fetch_addr", 64'(aq[g][i]), 64'(i));
    for (int i = 0; i < n; i++)
      if (!dis(mem[g][i])) ex.push_back(mem[g][i]);
    chk("n_start", 64'(sq[g].size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < sq[g].size(); i++)
      chk("rec_fields", 64'(sq[g][i]), 64'(ex[i]));
    chk("frame_done_cnt", 64'(fdc[g] - s_fd[g]), 64'(1));
    chk("busy_after", 64'(busy[g]), 64'(0));
    chk("field_stable", 64'(unstab[g] - s_un[g]), 64'(0));
    chk("done_to_fetch", 64'(gapbad[g] - s_gap[g]), 64'(0));
    chk("disabled_cost", 64'(disbad[g] - s_dis[g]), 64'(0));
    if (n > 0) begin
      chk("last_fields", 64'(flds(g)), 64'(mem[g][n-1]));
      chk("lat_mem_re", 64'(firstre[g] - t0[g]), 64'(1));
      if (!dis(mem[g][0]))
        chk("lat_start", 64'(firstst[g] - t0[g]), 64'(3));
    end else begin
      chk("lat_frame_done", 64'(fdcyc[g] - t0[g]), 64'(2));
      chk("busy_one_cycle", 64'(busyc[g] - s_busy[g]), 64'(1));
    end
  endtask

  task automatic rnd_fill(int g);
    for (int i = 0; i < 32; i++)
      mem[g][i] = rec(($urandom_range(0, 3) == 0) ? 4095 :
                      int'($urandom_range(0, 4094)),
                      int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 4095)));
  endtask

  task automatic set_t1(int g);
    mem[g][0] = rec(0, 10, 20, 8);
    mem[g][1] = rec(0, 100, 50, 16);
    mem[g][2] = rec(0, 5, 5, 1);
  endtask

  initial begin
    int k, f, na, c;
    rst_n = 1'b0;
    fs = '0;
    cnt = '0;
    noise = 1'b0;
    dly_fix = 0;
    rnd_fill(0);
    rnd_fill(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_a", outs(0), 64'(0));
    chk("rst_outs_b", outs(1), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs_a", outs(0), 64'(0));

    // three enabled records, 40-cycle draws
    set_t1(0);
    dly_fix = 39;
    launch(0, 3);
    wait_done(0, 1'b0);
    check_frame(0, 3);

    // empty list
    launch(0, 0);
    wait_done(0, 1'b0);
    check_frame(0, 0);

    // disabled first entry
    mem[0][0] = rec(4095, 1, 2, 3);
    mem[0][1] = rec(7, 11, 22, 33);
    dly_fix = 5;
    launch(0, 2);
    wait_done(0, 1'b0);
    check_frame(0, 2);

    // frame_start during a draw is ignored
    set_t1(0);
    dly_fix = 39;
    launch(0, 3);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_busy", 64'(busy[0]), 64'(1));
    cnt[0] = 6'd7;
    fs[0] = 1'b1;
    @(posedge clk); #1;
    fs[0] = 1'b0;
    wait_done(0, 1'b0);
    check_frame(0, 3);

    // reset in the middle of drawing record 1
    launch(0, 3);
    k = 0;
    while (sq[0].size() < 2 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5_reach_draw", 64'(k >= 500), 64'(0));
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", outs(0), 64'(0));
    f = fdc[0];
    na = aq[0].size();
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_no_frame_done", 64'(fdc[0] - f), 64'(0));
    chk("t5_no_fetch", 64'(aq[0].size() - na), 64'(0));
    launch(0, 3);
    wait_done(0, 1'b0);
    check_frame(0, 3);

    // small list, full and clamped counts
    dly_fix = 0;
    for (int i = 0; i < 4; i++)
      mem[1][i] = rec(i + 1, 3 * i, 5 * i, 9 * i + 2);
    launch(1, 4);
    wait_done(1, 1'b0);
    check_frame(1, 4);
    launch(1, 6);
    wait_done(1, 1'b0);
    check_frame(1, 6);

    // random lists with stray done pulses and ignored requests
    noise = 1'b1;
    for (int r = 0; r < 25; r++) begin
      rnd_fill(0);
      c = int'($urandom_range(0, 40));
      launch(0, c);
      wait_done(0, 1'b1);
      check_frame(0, c);
    end
    for (int r = 0; r < 10; r++) begin
      rnd_fill(1);
      c = int'($urandom_range(0, 7));
      launch(1, c);
      wait_done(1, 1'b1);
      check_frame(1, c);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
